// File: rtl/hawkes_step_ctrl.sv
// Step sequencer for the Hawkes state calculator: launches cfg_steps updates,
// folds each returned state back in, and accumulates intensity statistics.
module hawkes_step_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned XW      = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic             abort,
  input  logic [7:0]       cfg_steps,
  input  logic [7:0]       cfg_s,
  input  logic [1:0]       cfg_k,
  input  logic [16*XW-1:0] x_init,
  input  logic             st_done,
  input  logic [8:0]       st_lambda,
  input  logic [16*XW-1:0] st_x,
  output logic             st_start,
  output logic [7:0]       st_s,
  output logic [1:0]       st_k,
  output logic [16*XW-1:0] st_xin,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [7:0]       step_cnt,
  output logic [15:0]      lambda_acc,
  output logic [8:0]       lambda_max
);

  localparam int unsigned SW = 16 * XW;
  localparam int unsigned WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] TLAST = WW'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_LATCH, S_FIN} state_t;

  state_t        state, nxt;
  logic [7:0]    steps_q, steps_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic          st_start_d, busy_d, done_d, err_d;
  logic [7:0]    st_s_d, step_cnt_d;
  logic [1:0]    st_k_d;
  logic [SW-1:0] st_xin_d;
  logic [15:0]   lambda_acc_d;
  logic [8:0]    lambda_max_d;
  logic [16:0]   acc_sum;

  // Next-state and next-output logic
  always_comb begin
    nxt          = state;
    steps_d      = steps_q;
    wcnt_d       = wcnt_q;
    st_s_d       = st_s;
    st_k_d       = st_k;
    st_xin_d     = st_xin;
    err_d        = err;
    step_cnt_d   = step_cnt;
    lambda_acc_d = lambda_acc;
    lambda_max_d = lambda_max;
    done_d       = 1'b0;
    acc_sum      = 17'(lambda_acc) + 17'(st_lambda);

    case (state)
      S_IDLE: begin
        if (go) begin
          steps_d      = cfg_steps;
          st_s_d       = cfg_s;
          st_k_d       = cfg_k;
          st_xin_d     = x_init;
          err_d        = 1'b0;
          step_cnt_d   = '0;
          lambda_acc_d = '0;
          lambda_max_d = '0;
          nxt          = (cfg_steps == 8'd0) ? S_FIN : S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        wcnt_d = '0;
        nxt    = S_WAIT;
      end
      S_WAIT: begin
        // wcnt_q == 0 marks the first WAIT cycle, where a stale done is ignored
        wcnt_d = wcnt_q + WW'(1);
        if (st_done && (wcnt_q != '0)) begin
          nxt = S_LATCH;
        end else if (wcnt_q >= TLAST) begin
          err_d = 1'b1;
          nxt   = S_FIN;
        end
      end
      S_LATCH: begin
        st_xin_d     = st_x;
        lambda_acc_d = acc_sum[16] ? 16'hFFFF : acc_sum[15:0];
        lambda_max_d = (st_lambda > lambda_max) ? st_lambda : lambda_max;
        step_cnt_d   = step_cnt + 8'd1;
        nxt          = (step_cnt_d == steps_q) ? S_FIN : S_LAUNCH;
      end
      S_FIN: begin
        done_d = 1'b1;
        nxt    = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase

    // Cancel wins over everything and freezes the partial results
    if (abort && (state != S_IDLE)) begin
      nxt          = S_IDLE;
      wcnt_d       = wcnt_q;
      st_xin_d     = st_xin;
      err_d        = err;
      step_cnt_d   = step_cnt;
      lambda_acc_d = lambda_acc;
      lambda_max_d = lambda_max;
      done_d       = 1'b0;
    end

    st_start_d = (nxt == S_LAUNCH);
    busy_d     = (nxt != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      steps_q    <= '0;
      wcnt_q     <= '0;
      st_start   <= 1'b0;
      st_s       <= '0;
      st_k       <= '0;
      st_xin     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      step_cnt   <= '0;
      lambda_acc <= '0;
      lambda_max <= '0;
    end else begin
      state      <= nxt;
      steps_q    <= steps_d;
      wcnt_q     <= wcnt_d;
      st_start   <= st_start_d;
      st_s       <= st_s_d;
      st_k       <= st_k_d;
      st_xin     <= st_xin_d;
      busy       <= busy_d;
      done       <= done_d;
      err        <= err_d;
      step_cnt   <= step_cnt_d;
      lambda_acc <= lambda_acc_d;
      lambda_max <= lambda_max_d;
    end
  end

endmodule

// File: tb/tb_hawkes_step_ctrl.sv
// Bench for hawkes_step_ctrl: behavioural state calculator, vector table with
// a result scoreboard, plus timing, abort and reset sequences.
module tb_hawkes_step_ctrl;

  localparam int unsigned XW = 9;
  localparam int unsigned SW = 16 * XW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          go = 1'b0;
  logic          abort = 1'b0;
  logic [7:0]    cfg_steps = '0;
  logic [7:0]    cfg_s = '0;
  logic [1:0]    cfg_k = '0;
  logic [SW-1:0] x_init = '0;
  logic          st_done = 1'b0;
  logic [8:0]    st_lambda = '0;
  logic [SW-1:0] st_x;
  logic          st_start, busy, done, err;
  logic [7:0]    st_s, step_cnt;
  logic [1:0]    st_k;
  logic [SW-1:0] st_xin;
  logic [15:0]   lambda_acc;
  logic [8:0]    lambda_max;

  hawkes_step_ctrl #(.TIMEOUT(255), .XW(XW)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .abort(abort),
    .cfg_steps(cfg_steps), .cfg_s(cfg_s), .cfg_k(cfg_k), .x_init(x_init),
    .st_done(st_done), .st_lambda(st_lambda), .st_x(st_x),
    .st_start(st_start), .st_s(st_s), .st_k(st_k), .st_xin(st_xin),
    .busy(busy), .done(done), .err(err), .step_cnt(step_cnt),
    .lambda_acc(lambda_acc), .lambda_max(lambda_max)
  );

  always #5 clk = ~clk;

  // Calculator returns every element incremented
  for (genvar g = 0; g < 16; g++) begin : g_inc
    assign st_x[g*XW +: XW] = st_xin[g*XW +: XW] + XW'(1);
  end

  // Calculator model: 0 = done 4 cycles after start, 1 = done stuck high, 2 = stuck low
  int mode = 0, lam_base = 0, run_base = 0, starts_total = 0, done_total = 0;
  int dly = 0, lam_idx = 0;
  bit decr = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (mode == 1) st_done = 1'b1;
      else if (mode == 2) st_done = 1'b0;
      else if (st_start) begin dly = 4; st_done = 1'b0; end
      else if (dly > 0) begin dly--; if (dly == 0) st_done = 1'b1; end
      if (st_start) begin
        starts_total++;
        lam_idx = starts_total - run_base - 1;
        st_lambda = decr ? 9'(lam_base >> lam_idx) : 9'(lam_base);
      end
      if (done) done_total++;
    end
  end

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chkv(input string nm, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_st_start"}, int'(st_start), 0);
    chk({tag, "_st_s"}, int'(st_s), 0);
    chk({tag, "_st_k"}, int'(st_k), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_err"}, int'(err), 0);
    chk({tag, "_step_cnt"}, int'(step_cnt), 0);
    chk({tag, "_lambda_acc"}, int'(lambda_acc), 0);
    chk({tag, "_lambda_max"}, int'(lambda_max), 0);
    chkv({tag, "_st_xin"}, st_xin, '0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int steps; int lam; int mode; bit decr; bit disturb; bit abgo;
    int cnt; int acc; int mx; int err; int lat;
  } vec_t;

  typedef struct {
    int cnt; int acc; int mx; int err; int lat; int starts; int s; int k;
    logic [SW-1:0] xin;
  } exp_t;

  exp_t sbq[$];
  vec_t vt[9];

  task automatic run_vec(input vec_t v, input int seed);
    exp_t e, got;
    logic [SW-1:0] xi;
    int cyc;
    for (int i = 0; i < 16; i++) begin
      xi[i*XW +: XW]     = XW'(seed + i * 37);
      e.xin[i*XW +: XW]  = XW'(seed + i * 37 + v.cnt);
    end
    e.cnt = v.cnt; e.acc = v.acc; e.mx = v.mx; e.err = v.err; e.lat = v.lat;
    e.starts = v.steps; e.s = seed & 255; e.k = seed & 3;
    mode = v.mode; lam_base = v.lam; decr = v.decr; run_base = starts_total;
    cfg_steps = 8'(v.steps); cfg_s = 8'(seed); cfg_k = 2'(seed); x_init = xi;
    go = 1'b1; abort = v.abgo;
    sbq.push_back(e);
    tick();
    go = 1'b0; abort = 1'b0;
    chk("busy_after_go", int'(busy), 1);
    chk("err_clear_on_go", int'(err), 0);
    if (v.disturb) begin
      go = 1'b1; cfg_steps = 8'd1; cfg_s = ~cfg_s; cfg_k = ~cfg_k; x_init = '1;
    end
    cyc = 0;
    while (!done && cyc < 6000) begin
      tick();
      cyc++;
      if (cyc == 3) go = 1'b0;
    end
    if (!done) begin
      chk("done_timeout", 0, 1);
      if (sbq.size() > 0) void'(sbq.pop_front());
    end else if (sbq.size() == 0) begin
      chk("sb_unexpected_done", 0, 1);
    end else begin
      got = sbq.pop_front();
      chk("latency", cyc, got.lat);
      chk("step_cnt", int'(step_cnt), got.cnt);
      chk("lambda_acc", int'(lambda_acc), got.acc);
      chk("lambda_max", int'(lambda_max), got.mx);
      chk("err", int'(err), got.err);
      chk("starts", starts_total - run_base, got.starts);
      chk("st_s", int'(st_s), got.s);
      chk("st_k", int'(st_k), got.k);
      chk("busy_at_done", int'(busy), 0);
      chkv("st_xin", st_xin, got.xin);
    end
    tick();
    chk("done_one_cycle", int'(done), 0);
  endtask

  logic [9:0] exp_start, exp_done, exp_busy;
  int base_s, base_d, cyc;

  initial begin
    //        steps lam mode decr dist abgo  cnt  acc    mx   err lat
    vt[0] = '{3,   10,  0, 0, 0, 0,   3,   30,    10,  0, 19};
    vt[1] = '{0,   77,  0, 0, 0, 0,   0,   0,     0,   0, 1};
    vt[2] = '{2,   300, 1, 0, 0, 0,   2,   600,   300, 0, 9};
    vt[3] = '{1,   5,   2, 0, 0, 0,   0,   0,     0,   1, 257};
    vt[4] = '{4,   511, 1, 0, 1, 0,   4,   2044,  511, 0, 17};
    vt[5] = '{200, 511, 1, 0, 0, 0,   200, 65535, 511, 0, 801};
    vt[6] = '{5,   0,   0, 0, 0, 1,   5,   0,     0,   0, 31};
    vt[7] = '{255, 257, 1, 0, 0, 0,   255, 65535, 257, 0, 1021};
    vt[8] = '{3,   400, 0, 1, 0, 0,   3,   700,   400, 0, 19};

    // Reset values, and no spontaneous run after release
    repeat (2) tick();
    check_zero("reset");
    rst_n = 1'b1;
    repeat (4) tick();
    chk("idle_after_reset_busy", int'(busy), 0);
    chk("idle_after_reset_starts", starts_total, 0);

    for (int i = 0; i < 9; i++) run_vec(vt[i], 11 * i + 3);

    // Stale done held high: LAUNCH, blanked WAIT, WAIT, LATCH per step
    mode = 1; decr = 1'b0; lam_base = 1; run_base = starts_total;
    cfg_steps = 8'd2; x_init = '0; go = 1'b1;
    exp_start = 10'b0000010001;
    exp_done  = 10'b1000000000;
    exp_busy  = 10'b0111111111;
    tick();
    go = 1'b0;
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("stale_start_c%0d", c), int'(st_start), int'(exp_start[c]));
      chk($sformatf("stale_done_c%0d", c), int'(done), int'(exp_done[c]));
      chk($sformatf("stale_busy_c%0d", c), int'(busy), int'(exp_busy[c]));
      tick();
    end
    chk("stale_step_cnt", int'(step_cnt), 2);

    // Abort in WAIT of step 2
    mode = 0; lam_base = 20; run_base = starts_total;
    cfg_steps = 8'd3; go = 1'b1;
    tick();
    go = 1'b0;
    cyc = 0;
    while ((starts_total - run_base) < 2 && cyc < 100) begin tick(); cyc++; end
    chk("abort_reach_step2", starts_total - run_base, 2);
    abort = 1'b1;
    base_d = done_total;
    tick();
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_st_start", int'(st_start), 0);
    chk("abort_step_cnt", int'(step_cnt), 1);
    chk("abort_lambda_acc", int'(lambda_acc), 20);
    chk("abort_lambda_max", int'(lambda_max), 20);
    base_s = starts_total;
    repeat (12) tick();
    chk("abort_no_done", done_total - base_d, 0);
    chk("abort_no_restart", starts_total - base_s, 0);

    // Asynchronous reset while in LATCH of step 1
    run_base = starts_total;
    go = 1'b1;
    tick();
    go = 1'b0;
    repeat (5) tick();
    chk("rst_in_latch_state", int'(st_start | done), 0);
    #2 rst_n = 1'b0;
    #1 check_zero("rst_latch");
    tick();
    rst_n = 1'b1;
    base_s = starts_total;
    repeat (6) tick();
    chk("rst_no_restart_busy", int'(busy), 0);
    chk("rst_no_restart_starts", starts_total - base_s, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
